set_replacement_unit: RTL and testbench

- Parametrised per-set victim selector for N-way set-associative caches.
- Successor to the single-set replacement interface. Adds multiple sets, a compile-time choice between true-LRU and FIFO policy, and a registered query port.
- Sits beside the tag array in the cache controller. The controller reports hits and fills; on a miss it queries the victim way for the addressed set.

---
 rtl/set_replacement_unit.sv | 203 ++++++++++++++++++++
 tb/tb_set_replacement_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/set_replacement_unit.sv
`default_nettype none
// ============================================================================
// Module   : set_replacement_unit
// Purpose  : Per-set victim way selector for an N-way set-associative cache.
//            Tracks replacement state for every set and, when queried,
//            registers the victim way for the queried set.
//            MODE = 0 : true LRU, one age counter per way (0 = MRU).
//            MODE = 1 : FIFO, one round-robin fill pointer per set.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro : SET_REPLACEMENT_INVALID_PRIORITY_EN
//   Adds per-way valid bits and an invalidate port. The lowest-index invalid
//   way is then preferred over the policy victim.
// ----------------------------------------------------------------------------
// Ports
//   clock            in   rising-edge clock
//   reset            in   asynchronous reset, active low
//   enable           in   global update / output-hold control
//   accessValid      in   access to (accessSet, accessWay) this cycle
//   accessFill       in   1 = line fill, 0 = hit
//   accessSet        in   set index of the access
//   accessWay        in   way index of the access
//   queryValid       in   request a victim for querySet
//   querySet         in   set index of the query
//   invalidateValid  in   (macro only) clear valid bit of a way
//   invalidateSet    in   (macro only) set index of the invalidate
//   invalidateWay    in   (macro only) way index of the invalidate
//   replacementWay   out  registered victim way
//   replacementValid out  replacementWay answers the last query
// ============================================================================
module set_replacement_unit #(
  parameter int NUMBER_OF_WAYS = 4,
  parameter int NUMBER_OF_SETS = 1,
  parameter int MODE           = 0,
  parameter int WAY_WIDTH      = (NUMBER_OF_WAYS > 1) ? $clog2(NUMBER_OF_WAYS) : 1,
  parameter int SET_WIDTH      = (NUMBER_OF_SETS > 1) ? $clog2(NUMBER_OF_SETS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 accessValid,
  input  logic                 accessFill,
  input  logic [SET_WIDTH-1:0] accessSet,
  input  logic [WAY_WIDTH-1:0] accessWay,
  input  logic                 queryValid,
  input  logic [SET_WIDTH-1:0] querySet,
`ifdef SET_REPLACEMENT_INVALID_PRIORITY_EN
  input  logic                 invalidateValid,
  input  logic [SET_WIDTH-1:0] invalidateSet,
  input  logic [WAY_WIDTH-1:0] invalidateWay,
`endif
  output logic [WAY_WIDTH-1:0] replacementWay,
  output logic                 replacementValid
);

  localparam logic [WAY_WIDTH-1:0] c_lastWay = WAY_WIDTH'(NUMBER_OF_WAYS - 1);

  // Range qualification: out-of-range accesses are dropped, out-of-range
  // queries answer way 0. Safe indices keep array reads in bounds.
  logic                 w_accessWayOk;
  logic                 w_accessSetOk;
  logic                 w_querySetOk;
  logic                 w_accessEn;
  logic [SET_WIDTH-1:0] w_accessIdx;
  logic [SET_WIDTH-1:0] w_queryIdx;
  logic [WAY_WIDTH-1:0] w_policyVictim;
  logic [WAY_WIDTH-1:0] w_victim;

  assign w_accessWayOk = (32'(accessWay) < NUMBER_OF_WAYS);
  assign w_accessSetOk = (32'(accessSet) < NUMBER_OF_SETS);
  assign w_querySetOk  = (32'(querySet)  < NUMBER_OF_SETS);
  assign w_accessEn    = enable && accessValid && w_accessWayOk && w_accessSetOk;
  assign w_accessIdx   = w_accessSetOk ? accessSet : '0;
  assign w_queryIdx    = w_querySetOk  ? querySet  : '0;

  generate
    if (MODE == 0) begin : g_lru
      // Ages are a permutation of 0..NUMBER_OF_WAYS-1 per set; the way
      // holding the maximum age is the least recently used.
      logic [WAY_WIDTH-1:0] r_age [NUMBER_OF_SETS][NUMBER_OF_WAYS];
      logic [WAY_WIDTH-1:0] w_accessAge;
      logic                 w_unusedFill;

      // Hits and fills age the set identically.
      assign w_unusedFill = accessFill;

      always_comb begin
        w_accessAge = '0;
        for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
          if (WAY_WIDTH'(w) == accessWay) begin
            w_accessAge = r_age[w_accessIdx][w];
          end
        end
      end

      always_comb begin
        w_policyVictim = '0;
        for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
          if (r_age[w_queryIdx][w] == c_lastWay) begin
            w_policyVictim = WAY_WIDTH'(w);
          end
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < NUMBER_OF_SETS; s++) begin
            for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
              r_age[s][w] <= WAY_WIDTH'(w);
            end
          end
        end else if (w_accessEn) begin
          // Only ways younger than the accessed one age; older ones keep
          // their rank, which preserves the permutation.
          for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
            if (WAY_WIDTH'(w) == accessWay) begin
              r_age[w_accessIdx][w] <= '0;
            end else if (r_age[w_accessIdx][w] < w_accessAge) begin
              r_age[w_accessIdx][w] <= r_age[w_accessIdx][w] + WAY_WIDTH'(1);
            end
          end
        end
      end
    end else begin : g_fifo
      // One fill pointer per set; hits leave it untouched.
      logic [WAY_WIDTH-1:0] r_pointer [NUMBER_OF_SETS];

      assign w_policyVictim = r_pointer[w_queryIdx];

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < NUMBER_OF_SETS; s++) begin
            r_pointer[s] <= '0;
          end
        end else if (w_accessEn && accessFill) begin
          r_pointer[w_accessIdx] <= (r_pointer[w_accessIdx] == c_lastWay) ?
                                    '0 : r_pointer[w_accessIdx] + WAY_WIDTH'(1);
        end
      end
    end
  endgenerate

`ifdef SET_REPLACEMENT_INVALID_PRIORITY_EN
  logic [NUMBER_OF_WAYS-1:0] r_valid [NUMBER_OF_SETS];
  logic                      w_invalidateEn;
  logic [SET_WIDTH-1:0]      w_invalidateIdx;
  logic                      w_hasInvalid;
  logic [WAY_WIDTH-1:0]      w_invalidWay;

  assign w_invalidateEn  = enable && invalidateValid &&
                           (32'(invalidateWay) < NUMBER_OF_WAYS) &&
                           (32'(invalidateSet) < NUMBER_OF_SETS);
  assign w_invalidateIdx = (32'(invalidateSet) < NUMBER_OF_SETS) ? invalidateSet : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUMBER_OF_SETS; s++) begin
        r_valid[s] <= '0;
      end
    end else begin
      if (w_invalidateEn) begin
        r_valid[w_invalidateIdx][invalidateWay] <= 1'b0;
      end
      // Placed second so a fill to the same way in the same cycle wins.
      if (w_accessEn && accessFill) begin
        r_valid[w_accessIdx][accessWay] <= 1'b1;
      end
    end
  end

  // Scan downward so the lowest-index invalid way is the final pick.
  always_comb begin
    w_hasInvalid = 1'b0;
    w_invalidWay = '0;
    for (int w = NUMBER_OF_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_queryIdx][w]) begin
        w_hasInvalid = 1'b1;
        w_invalidWay = WAY_WIDTH'(w);
      end
    end
  end

  assign w_victim = w_hasInvalid ? w_invalidWay : w_policyVictim;
`else
  assign w_victim = w_policyVictim;
`endif

  // Query result is taken from pre-edge state: no bypass of a same-cycle
  // access to the queried set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      replacementWay   <= '0;
      replacementValid <= 1'b0;
    end else if (enable) begin
      replacementValid <= queryValid;
      if (queryValid) begin
        replacementWay <= w_querySetOk ? w_victim : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_set_replacement_unit.sv
`default_nettype none
module tb_set_replacement_unit;

  typedef struct {
    logic       en;
    logic       av;
    logic       af;
    logic [1:0] aset;
    logic [1:0] away;
    logic       qv;
    logic [1:0] qset;
    logic       iv;
    logic [1:0] iset;
    logic [1:0] iway;
    logic [1:0] lruWay;
    logic       lruValid;
    logic [1:0] fifoWay;
    logic       fifoValid;
  } vec_t;

  typedef struct {
    logic [1:0] lruWay;
    logic       lruValid;
    logic [1:0] fifoWay;
    logic       fifoValid;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       accessValid = 1'b0;
  logic       accessFill = 1'b0;
  logic [1:0] accessSet = '0;
  logic [1:0] accessWay = '0;
  logic       queryValid = 1'b0;
  logic [1:0] querySet = '0;
  logic       invalidateValid = 1'b0;
  logic [1:0] invalidateSet = '0;
  logic [1:0] invalidateWay = '0;
  logic [1:0] lruWay;
  logic       lruValid;
  logic [1:0] fifoWay;
  logic       fifoValid;

  int   assertions = 0;
  int   failures   = 0;
  exp_t expQ[$];
  vec_t vecs[$];

  always #5 clock = ~clock;

  set_replacement_unit #(.NUMBER_OF_WAYS(4), .NUMBER_OF_SETS(3), .MODE(0)) uLru (
    .clock(clock), .reset(reset), .enable(enable),
    .accessValid(accessValid), .accessFill(accessFill),
    .accessSet(accessSet), .accessWay(accessWay),
    .queryValid(queryValid), .querySet(querySet),
`ifdef SET_REPLACEMENT_INVALID_PRIORITY_EN
    .invalidateValid(invalidateValid), .invalidateSet(invalidateSet),
    .invalidateWay(invalidateWay),
`endif
    .replacementWay(lruWay), .replacementValid(lruValid)
  );

  set_replacement_unit #(.NUMBER_OF_WAYS(4), .NUMBER_OF_SETS(3), .MODE(1)) uFifo (
    .clock(clock), .reset(reset), .enable(enable),
    .accessValid(accessValid), .accessFill(accessFill),
    .accessSet(accessSet), .accessWay(accessWay),
    .queryValid(queryValid), .querySet(querySet),
`ifdef SET_REPLACEMENT_INVALID_PRIORITY_EN
    .invalidateValid(invalidateValid), .invalidateSet(invalidateSet),
    .invalidateWay(invalidateWay),
`endif
    .replacementWay(fifoWay), .replacementValid(fifoValid)
  );

  function automatic vec_t mk(input logic en, input logic av, input logic af,
                              input logic [1:0] aset, input logic [1:0] away,
                              input logic qv, input logic [1:0] qset,
                              input logic [1:0] lw, input logic lv,
                              input logic [1:0] fw, input logic fv,
                              input logic iv = 1'b0, input logic [1:0] iset = 2'd0,
                              input logic [1:0] iway = 2'd0);
    vec_t v;
    v.en = en; v.av = av; v.af = af; v.aset = aset; v.away = away;
    v.qv = qv; v.qset = qset; v.iv = iv; v.iset = iset; v.iway = iway;
    v.lruWay = lw; v.lruValid = lv; v.fifoWay = fw; v.fifoValid = fv;
    return v;
  endfunction

  task automatic check(input string name, input int id, input int got, input int exp);
    assertions++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, id, got, exp);
    end
  endtask

  task automatic idle();
    enable = 1'b0; accessValid = 1'b0; accessFill = 1'b0; accessSet = '0;
    accessWay = '0; queryValid = 1'b0; querySet = '0;
    invalidateValid = 1'b0; invalidateSet = '0; invalidateWay = '0;
  endtask

  task automatic resetDut();
    @(negedge clock);
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic applyVec(input vec_t v, input int id);
    exp_t e;
    @(negedge clock);
    enable = v.en; accessValid = v.av; accessFill = v.af;
    accessSet = v.aset; accessWay = v.away; queryValid = v.qv; querySet = v.qset;
    invalidateValid = v.iv; invalidateSet = v.iset; invalidateWay = v.iway;
    expQ.push_back('{v.lruWay, v.lruValid, v.fifoWay, v.fifoValid});
    @(posedge clock);
    #1;
    e = expQ.pop_front();
    check("lru_way",    id, int'(lruWay),    int'(e.lruWay));
    check("lru_valid",  id, int'(lruValid),  int'(e.lruValid));
    check("fifo_way",   id, int'(fifoWay),   int'(e.fifoWay));
    check("fifo_valid", id, int'(fifoValid), int'(e.fifoValid));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_lru_way",    0, int'(lruWay),    0);
    check("reset_lru_valid",  0, int'(lruValid),  0);
    check("reset_fifo_way",   0, int'(fifoWay),   0);
    check("reset_fifo_valid", 0, int'(fifoValid), 0);

`ifndef SET_REPLACEMENT_INVALID_PRIORITY_EN
    //             en av af as aw qv qs  lw lv fw fv
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 3, 1, 0, 1)); // query from reset
    vecs.push_back(mk(1, 1, 0, 0, 3, 0, 0, 3, 0, 0, 0)); // hit s0 w3
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 3, 0, 0, 0)); // fill s0 w0
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 2, 0, 0, 2, 0, 1, 0)); // hit s0 w2
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 1, 2, 0, 0, 1, 0, 1, 0)); // hit s1 w2
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 3, 1, 0, 1)); // fifo ignores hit
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 1, 1, 1, 3, 0, 0, 3, 0, 0, 0)); // four fills s1
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1)); // pointer wrapped
    vecs.push_back(mk(1, 1, 1, 1, 3, 1, 1, 1, 1, 0, 1)); // fifth fill + query
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1)); // disabled: hold
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1)); // state untouched
    vecs.push_back(mk(1, 1, 1, 3, 0, 1, 3, 0, 1, 0, 1)); // out-of-range set
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 2, 3, 1, 0, 1)); // untouched set 2
    foreach (vecs[i]) applyVec(vecs[i], i + 1);

    // Same-cycle access and query from reset: pre-update victim returned.
    resetDut();
    applyVec(mk(1, 1, 0, 0, 3, 1, 0, 3, 1, 0, 1), 101);
    applyVec(mk(1, 0, 0, 0, 0, 1, 0, 2, 1, 0, 1), 102);

    // Asynchronous reset mid-cycle.
    applyVec(mk(1, 1, 1, 0, 1, 0, 0, 2, 0, 0, 0), 201);
    applyVec(mk(1, 0, 0, 0, 0, 1, 0, 2, 1, 1, 1), 202);
    #2;
    reset = 1'b0;
    #1;
    check("async_lru_valid",  203, int'(lruValid),  0);
    check("async_lru_way",    203, int'(lruWay),    0);
    check("async_fifo_valid", 203, int'(fifoValid), 0);
    check("async_fifo_way",   203, int'(fifoWay),   0);
    idle();
    @(negedge clock);
    reset = 1'b1;
    applyVec(mk(1, 0, 0, 0, 0, 1, 0, 3, 1, 0, 1), 204);
`else
    //             en av af as aw qv qs  lw lv fw fv  iv is iw
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1)); // all invalid
    for (int w = 0; w < 4; w++)
      vecs.push_back(mk(1, 1, 1, 0, 2'(w), 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1)); // policy victims
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2)); // inv w2
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2, 1, 2, 1));
    vecs.push_back(mk(1, 1, 1, 0, 2, 0, 0, 2, 0, 2, 0, 1, 0, 2)); // fill wins
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1));
    foreach (vecs[i]) applyVec(vecs[i], i + 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
`default_nettype wire
